// File: rtl/n64_readcmd_tx.sv
// N64 controller link command transmitter: sends the poll byte and stop bit on the
// open-drain line, then opens the receiver's response window.
module n64_readcmd_tx #(
    parameter int          POLL_CYCLES = 66667,
    parameter int          RESP_CYCLES = 600,
    parameter logic [7:0]  CMD         = 8'h01
) (
    input  logic       clk_4M,
    input  logic       reset,
    input  logic       poll_en,
    output logic       dout_oe,
    output logic       rx_enable,
    output logic       busy,
    output logic       frame_done,
    output logic [1:0] state_dbg
);

    localparam int IW = $clog2(POLL_CYCLES + 1);
    localparam int RW = $clog2(RESP_CYCLES + 1);
    localparam int PW = (RW > 3) ? RW : 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_STOP = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [IW-1:0]   idle_cnt, idle_n;
    logic [3:0]      slot_cnt, slot_n;
    logic [2:0]      bit_idx, bit_n;
    logic [PW-1:0]   phase_cnt, phase_n;
    logic            oe_n, rx_n, fd_n;

    always_ff @(posedge clk_4M or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            idle_cnt   <= '0;
            slot_cnt   <= '0;
            bit_idx    <= '0;
            phase_cnt  <= '0;
            dout_oe    <= 1'b0;
            rx_enable  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            idle_cnt   <= idle_n;
            slot_cnt   <= slot_n;
            bit_idx    <= bit_n;
            phase_cnt  <= phase_n;
            dout_oe    <= oe_n;
            rx_enable  <= rx_n;
            frame_done <= fd_n;
        end
    end

    always_comb begin
        state_n = state;
        idle_n  = idle_cnt;
        slot_n  = slot_cnt;
        bit_n   = bit_idx;
        phase_n = phase_cnt;
        fd_n    = 1'b0;
        case (state)
            S_IDLE: begin
                // The frame_done cycle is not counted, so the idle gap restarts after it.
                if (!poll_en) begin
                    idle_n = '0;
                end else if (frame_done) begin
                    idle_n = '0;
                end else if (idle_cnt == IW'(POLL_CYCLES - 1)) begin
                    state_n = S_CMD;
                    idle_n  = '0;
                    slot_n  = '0;
                    bit_n   = 3'd7;
                end else begin
                    idle_n = idle_cnt + 1'b1;
                end
            end
            S_CMD: begin
                slot_n = slot_cnt + 1'b1;
                if (slot_cnt == 4'd15) begin
                    if (bit_idx == 3'd0) begin
                        state_n = S_STOP;
                        phase_n = '0;
                    end else begin
                        bit_n = bit_idx - 1'b1;
                    end
                end
            end
            S_STOP: begin
                phase_n = phase_cnt + 1'b1;
                if (phase_cnt == PW'(7)) begin
                    state_n = S_RESP;
                    phase_n = '0;
                end
            end
            S_RESP: begin
                phase_n = phase_cnt + 1'b1;
                if (phase_cnt == PW'(RESP_CYCLES - 1)) begin
                    state_n = S_IDLE;
                    phase_n = '0;
                    fd_n    = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so the line moves on cycle 0.
    always_comb begin
        oe_n = 1'b0;
        rx_n = 1'b0;
        case (state_n)
            S_CMD:   oe_n = CMD[bit_n] ? (slot_n < 4'd4) : (slot_n < 4'd12);
            S_STOP:  oe_n = (phase_n < PW'(4));
            S_RESP:  rx_n = 1'b1;
            default: oe_n = 1'b0;
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_n64_readcmd_tx.sv
// Directed bench for n64_readcmd_tx: frame timing, CMD encoding, poll drop,
// mid-frame reset and a loopback against a small controller/receiver model.
`timescale 1ns/1ps
module tb_n64_readcmd_tx;

    localparam int POLL_A = 10;
    localparam int POLL_B = 12;
    localparam int RESP   = 600;
    localparam int FL     = 740;

    logic clk = 1'b0;
    always #125 clk = ~clk;

    logic       rst_a, poll_a, oe_a, rxe_a, busy_a, fd_a;
    logic       rst_b, poll_b, oe_b, rxe_b, busy_b, fd_b;
    logic [1:0] st_a, st_b;
    logic       sel;
    logic       oe_s, rxe_s, busy_s, fd_s;

    n64_readcmd_tx #(.POLL_CYCLES(POLL_A), .RESP_CYCLES(RESP), .CMD(8'h01)) dut_a (
        .clk_4M(clk), .reset(rst_a), .poll_en(poll_a), .dout_oe(oe_a),
        .rx_enable(rxe_a), .busy(busy_a), .frame_done(fd_a), .state_dbg(st_a)
    );

    n64_readcmd_tx #(.POLL_CYCLES(POLL_B), .RESP_CYCLES(RESP), .CMD(8'hA5)) dut_b (
        .clk_4M(clk), .reset(rst_b), .poll_en(poll_b), .dout_oe(oe_b),
        .rx_enable(rxe_b), .busy(busy_b), .frame_done(fd_b), .state_dbg(st_b)
    );

    assign oe_s   = sel ? oe_b   : oe_a;
    assign rxe_s  = sel ? rxe_b  : rxe_a;
    assign busy_s = sel ? busy_b : busy_a;
    assign fd_s   = sel ? fd_b   : fd_a;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_rise(output int n, input int limit);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!oe_s && n < limit);
    endtask

    task automatic wait_fd(output int n, input int limit);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fd_s && n < limit);
    endtask

    logic cap_oe [FL];
    logic cap_rx [FL];
    logic cap_bs [FL];
    logic cap_fd [FL];

    // Index 0 is the sample of the current negedge, i.e. frame cycle 0.
    task automatic capture();
        for (int i = 0; i < FL; i++) begin
            if (i > 0) @(negedge clk);
            cap_oe[i] = oe_s;
            cap_rx[i] = rxe_s;
            cap_bs[i] = busy_s;
            cap_fd[i] = fd_s;
        end
    endtask

    task automatic analyze(input logic [7:0] cmd, input string tag);
        int run_start [16];
        int run_width [16];
        int nruns, rx_first, rx_cnt, overlap, fd_cnt, fd_idx, busy_cnt;
        int exp_w;
        logic [7:0] c;
        c = cmd;
        nruns = 0; rx_first = -1; rx_cnt = 0; overlap = 0;
        fd_cnt = 0; fd_idx = -1; busy_cnt = 0;
        for (int i = 0; i < FL; i++) begin
            if (cap_oe[i] && (i == 0 || !cap_oe[i-1])) begin
                if (nruns < 16) begin
                    run_start[nruns] = i;
                    run_width[nruns] = 0;
                end
                nruns++;
            end
            if (cap_oe[i] && nruns > 0 && nruns <= 16) run_width[nruns-1]++;
            if (cap_rx[i]) begin
                if (rx_first < 0) rx_first = i;
                rx_cnt++;
            end
            if (cap_rx[i] && cap_oe[i]) overlap++;
            if (cap_fd[i]) begin
                fd_cnt++;
                fd_idx = i;
            end
            if (i < 136 + RESP && cap_bs[i]) busy_cnt++;
        end
        check_eq({tag, "_nruns"}, nruns, 9);
        if (nruns == 9) begin
            for (int k = 0; k < 9; k++) begin
                exp_w = (k == 8) ? 4 : (c[7-k] ? 4 : 12);
                check_eq($sformatf("%s_start%0d", tag, k), run_start[k], 16 * k);
                check_eq($sformatf("%s_width%0d", tag, k), run_width[k], exp_w);
            end
        end
        check_eq({tag, "_rx_first"}, rx_first, 136);
        check_eq({tag, "_rx_len"}, rx_cnt, RESP);
        check_eq({tag, "_overlap"}, overlap, 0);
        check_eq({tag, "_fd_cnt"}, fd_cnt, 1);
        check_eq({tag, "_fd_idx"}, fd_idx, 136 + RESP);
        check_eq({tag, "_busy_cnt"}, busy_cnt, 136 + RESP);
        check_eq({tag, "_busy_end"}, cap_bs[136 + RESP], 0);
    endtask

    // Controller and receiver models sharing the open-drain line of dut_a.
    logic        ctrl_low;
    logic        line;
    logic        line_q, rxe_q;
    logic [31:0] rx_data;
    int          rx_edges, rx_bits, low_len;

    assign line = !(oe_a || ctrl_low);

    always @(posedge clk) begin
        rxe_q  <= rxe_a;
        line_q <= line;
        if (rxe_a && !rxe_q) begin
            rx_data  <= '0;
            rx_edges <= 0;
            rx_bits  <= 0;
            low_len  <= 0;
        end else if (rxe_a) begin
            if (line_q && !line) begin
                rx_edges <= rx_edges + 1;
                low_len  <= 1;
            end else if (!line) begin
                low_len <= low_len + 1;
            end else if (!line_q && line) begin
                if (rx_bits < 32) rx_data <= {rx_data[30:0], (low_len < 8)};
                rx_bits <= rx_bits + 1;
            end
        end
    end

    task automatic send_reply(input logic [31:0] word);
        logic [31:0] w;
        int lw;
        w = word;
        for (int k = 31; k >= -1; k--) begin
            lw = (k < 0) ? 4 : (w[k] ? 4 : 12);
            ctrl_low = 1'b1;
            step(lw);
            ctrl_low = 1'b0;
            step(16 - lw);
        end
    endtask

    initial begin
        int n, cnt_oe, cnt_busy;
        rst_a = 1'b1; rst_b = 1'b1; poll_a = 1'b0; poll_b = 1'b0;
        ctrl_low = 1'b0; sel = 1'b0;
        step(3);
        check_eq("rst_oe", oe_a, 0);
        check_eq("rst_rx", rxe_a, 0);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_fd", fd_a, 0);
        check_eq("rst_state", st_a, 0);
        rst_a = 1'b0; rst_b = 1'b0;
        step(2);
        check_eq("idle_oe", oe_a, 0);

        // First frame and frame period
        poll_a = 1'b1;
        wait_rise(n, 100);
        check_eq("first_rise", n, POLL_A);
        capture();
        analyze(8'h01, "f1");
        wait_rise(n, 100);
        check_eq("period_gap", n, 136 + RESP + POLL_A + 1 - FL + 1);

        // poll_en drop at cycle 50 of a frame
        step(50);
        poll_a = 1'b0;
        wait_fd(n, 1000);
        check_eq("drop_fd_at", n, 136 + RESP - 50);
        cnt_oe = 0; cnt_busy = 0;
        for (int i = 0; i < 3 * POLL_A + 10; i++) begin
            @(negedge clk);
            if (oe_a) cnt_oe++;
            if (busy_a) cnt_busy++;
        end
        check_eq("drop_quiet_oe", cnt_oe, 0);
        check_eq("drop_quiet_busy", cnt_busy, 0);

        // Reset at cycle 70, mid-bit with the line pulled low
        poll_a = 1'b1;
        wait_rise(n, 100);
        check_eq("rst_test_rise", n, POLL_A);
        step(70);
        check_eq("rst_pre_oe", oe_a, 1);
        check_eq("rst_pre_busy", busy_a, 1);
        rst_a = 1'b1;
        #1;
        check_eq("rst_async_oe", oe_a, 0);
        check_eq("rst_async_rx", rxe_a, 0);
        check_eq("rst_async_busy", busy_a, 0);
        step(3);
        rst_a = 1'b0;
        wait_rise(n, 100);
        check_eq("rst_restart_rise", n, POLL_A);
        capture();
        analyze(8'h01, "f_rst");

        // Loopback over three consecutive frames
        for (int f = 0; f < 3; f++) begin
            wait_rise(n, 100);
            check_eq($sformatf("lb%0d_rise", f), n, (f == 0) ? (136 + RESP + POLL_A + 2 - FL) : (POLL_A + 1));
            n = 0;
            while (!rxe_a && n < 300) begin
                @(negedge clk);
                n++;
            end
            check_eq($sformatf("lb%0d_rx_start", f), n, 136);
            step(4);
            send_reply(32'h8000_0000);
            wait_fd(n, 300);
            check_eq($sformatf("lb%0d_fd", f), fd_a, 1);
            check_eq($sformatf("lb%0d_data", f), rx_data, 32'h8000_0000);
            check_eq($sformatf("lb%0d_edges", f), rx_edges, 33);
            check_eq($sformatf("lb%0d_bits", f), rx_bits, 33);
        end
        poll_a = 1'b0;

        // CMD = 8'hA5 on the second instance
        sel = 1'b1;
        step(2);
        poll_b = 1'b1;
        wait_rise(n, 100);
        check_eq("a5_rise", n, POLL_B);
        capture();
        analyze(8'hA5, "a5");
        poll_b = 1'b0;
        step(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
